// File: rtl/i2c_mem_target_if.sv
// Bus-side signal bundle for the I2C memory target.
// The slave modport is the target's view; the master modport is the bus/host side.
interface i2c_mem_target_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic       busy;
  logic       wr_pulse;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_nack;

  modport slave (
    input  scl_in, sda_in,
    output sda_oe, busy, wr_pulse, wr_addr, wr_data, rd_nack
  );

  modport master (
    output scl_in, sda_in,
    input  sda_oe, busy, wr_pulse, wr_addr, wr_data, rd_nack
  );
endinterface

// File: rtl/i2c_mem_target.sv
// I2C target backed by a 128x8 memory. Every 7-bit address is ACKed and used
// as the starting memory pointer; writes and reads auto-increment (mod 128).
// SCL/SDA are oversampled on clk; sda_oe=1 pulls SDA low (open-drain).
module i2c_mem_target #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  i2c_mem_target_if.slave        bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;
  state_t                 state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [6:0]             ptr_q, ptr_d;
  logic                   rw_q, rw_d;
  logic                   nacked_q, nacked_d;
  logic                   sda_oe_q, sda_oe_d;
  logic                   busy_q, busy_d;
  logic                   wr_pulse_q, wr_pulse_d;
  logic                   rd_nack_q, rd_nack_d;
  logic [6:0]             wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;

  logic                   scl_s, sda_s;
  logic                   scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0]             byte_s;
  logic [6:0]             ptr_inc_s;
  logic [7:0]             rd_byte_s, nxt_byte_s;
  logic                   mem_we_s;
  logic [7:0]             mem [0:127];

  // Synchronized line levels, edge and bus-condition detection
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
    scl_s      = scl_sync_q[SYNC_STAGES-1];
    sda_s      = sda_sync_q[SYNC_STAGES-1];
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
    scl_rise_s = scl_s & ~scl_prev_q;
    scl_fall_s = ~scl_s & scl_prev_q;
    start_s    = scl_s & sda_prev_q & ~sda_s;
    stop_s     = scl_s & ~sda_prev_q & sda_s;
    byte_s     = {shift_q[6:0], sda_s};
    ptr_inc_s  = ptr_q + 7'd1;
    rd_byte_s  = mem[ptr_q];
    nxt_byte_s = mem[ptr_inc_s];
  end

  // Protocol FSM: next state, shift/count/pointer updates and output strobes
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    nacked_d   = nacked_q;
    sda_oe_d   = sda_oe_q;
    wr_pulse_d = 1'b0;
    rd_nack_d  = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we_s   = 1'b0;
    if (stop_s) begin
      state_d   = IDLE;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (start_s) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      nacked_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sda_oe_d = 1'b0;
        end
        ADDR: begin
          if (scl_rise_s) begin
            shift_d = byte_s;
            if (bit_cnt_q == 4'd7) begin
              ptr_d     = byte_s[7:1];
              rw_d      = byte_s[0];
              bit_cnt_d = 4'd0;
              state_d   = ADDR_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        ADDR_ACK: begin
          // sda_oe doubles as the ACK phase marker: first fall drives, second releases
          if (scl_fall_s) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q) begin
              // This fall already opens bit 7 of the first read byte
              state_d   = RD_DATA;
              shift_d   = rd_byte_s;
              sda_oe_d  = ~rd_byte_s[7];
              bit_cnt_d = 4'd1;
            end else begin
              state_d   = WR_DATA;
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        WR_DATA: begin
          if (scl_rise_s) begin
            shift_d = byte_s;
            if (bit_cnt_q == 4'd7) begin
              mem_we_s   = 1'b1;
              wr_pulse_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = byte_s;
              bit_cnt_d  = 4'd0;
              state_d    = WR_ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            shift_d = shift_q;
          end
        end
        WR_ACK: begin
          if (scl_fall_s) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              ptr_d     = ptr_inc_s;
              bit_cnt_d = 4'd0;
              state_d   = WR_DATA;
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        RD_DATA: begin
          // bit_cnt counts bits already placed on the bus
          if (scl_fall_s) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              nacked_d  = 1'b0;
              state_d   = RD_ACK;
            end else begin
              sda_oe_d  = ~shift_q[3'd7 - bit_cnt_q[2:0]];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        RD_ACK: begin
          // After a NACK, further SCL rises are ignored until START/STOP
          if (scl_rise_s && !nacked_q) begin
            if (sda_s) begin
              rd_nack_d = 1'b1;
              nacked_d  = 1'b1;
              sda_oe_d  = 1'b0;
            end else begin
              ptr_d     = ptr_inc_s;
              shift_d   = nxt_byte_s;
              bit_cnt_d = 4'd0;
              state_d   = RD_DATA;
            end
          end else begin
            sda_oe_d = 1'b0;
          end
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_sync_q <= {SYNC_STAGES{1'b1}};
      sda_sync_q <= {SYNC_STAGES{1'b1}};
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      ptr_q      <= 7'd0;
      rw_q       <= 1'b0;
      nacked_q   <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      rd_nack_q  <= 1'b0;
      wr_addr_q  <= 7'd0;
      wr_data_q  <= 8'd0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      nacked_q   <= nacked_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      rd_nack_q  <= rd_nack_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Byte storage: written only on a completed data byte, contents never reset
  always_ff @(posedge clk) begin
    if (reset_n && mem_we_s) begin
      mem[ptr_q] <= byte_s;
    end
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.busy     = busy_q;
  assign bus.wr_pulse = wr_pulse_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.rd_nack  = rd_nack_q;

endmodule
